// File: rtl/ev20_pkg.sv
// Shared MicroEV20 definitions: return-address stack sizing and sequencer states.
package ev20_pkg;

  localparam int AW_PC     = 11;
  localparam int RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    JUMP,
    POP,
    LOAD
  } ras_state_t;

  // Occupancy counter needs one extra bit to represent a completely full stack.
  function automatic int depth_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/return_addr_unit_if.sv
// Decode-side bundle of the return-address unit: CALL/RET requests in, PC load and status out.
interface return_addr_unit_if
  import ev20_pkg::*;
#(
  parameter int AW    = AW_PC,
  parameter int DEPTH = RAS_DEPTH
);

  localparam int DW = depth_width(DEPTH);

  logic          enable;
  logic          call;
  logic          ret;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] target;
  logic [AW-1:0] pc_out;
  logic          pc_load;
  logic          busy;
  logic [DW-1:0] depth;
  logic          overflow;
  logic          underflow;

  modport master (
    output enable, call, ret, pc_in, target,
    input  pc_out, pc_load, busy, depth, overflow, underflow
  );

  modport slave (
    input  enable, call, ret, pc_in, target,
    output pc_out, pc_load, busy, depth, overflow, underflow
  );

endinterface

// File: rtl/lifo_store.sv
// LIFO storage for return addresses; the occupancy counter doubles as the stack pointer.
module lifo_store
  import ev20_pkg::*;
#(
  parameter  int AW    = AW_PC,
  parameter  int DEPTH = RAS_DEPTH,
  localparam int DW    = depth_width(DEPTH)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] rdata,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic [IW-1:0] wr_idx, rd_idx;

  // Index arithmetic wraps at DEPTH, so a full stack still reads its top at DEPTH-1.
  assign wr_idx = depth_q[IW-1:0];
  assign rd_idx = wr_idx - IW'(1);

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;
  assign rdata = mem[rd_idx];

  always_comb begin
    depth_d = depth_q;
    if (push && !full) begin
      depth_d = depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/return_addr_unit.sv
// CALL/RET sequencer for the MicroEV20 core: pushes return addresses, pops them back
// and issues a single-cycle PC load strobe for each accepted request.
module return_addr_unit
  import ev20_pkg::*;
#(
  parameter int AW    = AW_PC,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic               clk,
  input  logic               clear_n,
  return_addr_unit_if.slave  bus
);

  localparam int DW = depth_width(DEPTH);

  ras_state_t    state_q, state_d;
  logic [AW-1:0] pc_out_q, pc_out_d;
  logic          pc_load_q, pc_load_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          push, pop, full, empty;
  logic [AW-1:0] ret_addr, top_addr;
  logic [DW-1:0] lifo_depth;

  assign ret_addr = bus.pc_in + AW'(1);

  lifo_store #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk     (clk),
    .clear_n (clear_n),
    .push    (push),
    .pop     (pop),
    .wdata   (ret_addr),
    .rdata   (top_addr),
    .depth   (lifo_depth),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d     = state_q;
    pc_out_d    = pc_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push        = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && bus.call) begin
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            push     = 1'b1;
            pc_out_d = bus.target;
            state_d  = JUMP;
          end
        end else if (bus.enable && bus.ret) begin
          if (empty) begin
            underflow_d = 1'b1;
          end else begin
            pop      = 1'b1;
            pc_out_d = top_addr;
            state_d  = POP;
          end
        end
      end
      JUMP:    state_d = IDLE;
      POP:     state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobe and busy are registered copies of where the sequencer is heading.
    pc_load_d = (state_d == JUMP) || (state_d == LOAD);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      pc_out_q    <= '0;
      pc_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_out_q    <= pc_out_d;
      pc_load_q   <= pc_load_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.pc_out    = pc_out_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.busy      = busy_q;
  assign bus.depth     = lifo_depth;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule
